// File: rtl/brick_field_if.sv
// Bus between the ball/renderer side and the brick wall controller:
// frame strobes, ball position, and the wall/score/bounce state.
interface brick_field_if #(
    parameter int N = 32
);
    logic           i_ani_stb;
    logic           i_animate;
    logic           i_load;
    logic           i_col_ack;
    logic [11:0]    s_x;
    logic [11:0]    s_y;
    logic [N-1:0]   o_alive;
    logic [8:0]     o_score;
    logic           o_hit;
    logic [1:0]     o_hit_dir;
    logic [5:0]     o_hit_idx;
    logic           o_busy;
    logic           o_clear;

    modport master (
        output i_ani_stb, i_animate, i_load, i_col_ack, s_x, s_y,
        input  o_alive, o_score, o_hit, o_hit_dir, o_hit_idx, o_busy, o_clear
    );

    modport slave (
        input  i_ani_stb, i_animate, i_load, i_col_ack, s_x, s_y,
        output o_alive, o_score, o_hit, o_hit_dir, o_hit_idx, o_busy, o_clear
    );
endinterface

// File: rtl/brick_field_ctrl.sv
// Breakout brick wall held as one alive bitmap; each frame the latched ball
// is tested against the bricks one per clock and the first overlap is retired.
module brick_field_ctrl #(
    parameter int ROWS     = 4,
    parameter int COLS     = 8,
    parameter int X0       = 60,
    parameter int Y0       = 40,
    parameter int PITCH_X  = 74,
    parameter int PITCH_Y  = 16,
    parameter int B_WIDTH  = 30,
    parameter int B_HEIGHT = 5,
    parameter int S_SIZE   = 5
) (
    input  logic          i_clk,
    input  logic          i_rst,
    brick_field_if.slave  bus
);
    localparam int N = ROWS * COLS;

    typedef enum logic [1:0] {ST_IDLE, ST_SCAN, ST_DONE} state_t;

    state_t         state_q, state_d;
    logic [5:0]     idx_q, idx_d;
    logic [5:0]     row_q, row_d;
    logic [5:0]     col_q, col_d;
    logic [11:0]    lx_q, lx_d;
    logic [11:0]    ly_q, ly_d;
    logic [N-1:0]   alive_q, alive_d;
    logic [8:0]     score_q, score_d;
    logic           hit_q, hit_d;
    logic [1:0]     dir_q, dir_d;
    logic [5:0]     hit_idx_q, hit_idx_d;

    logic signed [12:0] cx, cy, dx, dy, adx, ady;
    logic signed [13:0] mx, my;
    logic [63:0]        alive_ext;
    logic [N-1:0]       retire_mask;
    logic               hit_now;
    logic [1:0]         dir_now;

    // Row/col counters track idx so brick centres need no divide.
    always_comb begin
        cx  = 13'(X0 + int'(col_q) * PITCH_X);
        cy  = 13'(Y0 + int'(row_q) * PITCH_Y);
        dx  = $signed({1'b0, lx_q}) - cx;
        dy  = $signed({1'b0, ly_q}) - cy;
        adx = dx[12] ? -dx : dx;
        ady = dy[12] ? -dy : dy;
        mx  = $signed(14'(B_WIDTH + S_SIZE)) - 14'(adx);
        my  = $signed(14'(B_HEIGHT + S_SIZE)) - 14'(ady);
        alive_ext   = 64'(alive_q);
        retire_mask = N'(64'd1 << idx_q);
        hit_now = (state_q == ST_SCAN) && alive_ext[idx_q] && !mx[13] && !my[13];
        if (mx == my) begin
            dir_now = 2'b11;
        end else if (my < mx) begin
            dir_now = 2'b01;
        end else begin
            dir_now = 2'b10;
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        row_d     = row_q;
        col_d     = col_q;
        lx_d      = lx_q;
        ly_d      = ly_q;
        alive_d   = alive_q;
        score_d   = score_q;
        hit_d     = 1'b0;
        dir_d     = dir_q;
        hit_idx_d = hit_idx_q;

        if (bus.i_load) begin
            alive_d = '1;
            score_d = '0;
            dir_d   = 2'b00;
            state_d = ST_IDLE;
        end else begin
            // A fresh hit below overrides this acknowledge.
            if (bus.i_col_ack) begin
                dir_d = 2'b00;
            end
            unique case (state_q)
                ST_IDLE: begin
                    if (bus.i_ani_stb && bus.i_animate) begin
                        lx_d    = bus.s_x;
                        ly_d    = bus.s_y;
                        idx_d   = '0;
                        row_d   = '0;
                        col_d   = '0;
                        state_d = ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    if (hit_now) begin
                        alive_d   = alive_q & ~retire_mask;
                        score_d   = (score_q == 9'd511) ? score_q : score_q + 9'd1;
                        hit_d     = 1'b1;
                        hit_idx_d = idx_q;
                        dir_d     = dir_now;
                        state_d   = ST_DONE;
                    end else if (idx_q == 6'(N - 1)) begin
                        state_d = ST_DONE;
                    end else begin
                        idx_d = idx_q + 6'd1;
                        if (col_q == 6'(COLS - 1)) begin
                            col_d = '0;
                            row_d = row_q + 6'd1;
                        end else begin
                            col_d = col_q + 6'd1;
                        end
                    end
                end
                ST_DONE: state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            row_q     <= '0;
            col_q     <= '0;
            lx_q      <= '0;
            ly_q      <= '0;
            alive_q   <= '1;
            score_q   <= '0;
            hit_q     <= 1'b0;
            dir_q     <= 2'b00;
            hit_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            row_q     <= row_d;
            col_q     <= col_d;
            lx_q      <= lx_d;
            ly_q      <= ly_d;
            alive_q   <= alive_d;
            score_q   <= score_d;
            hit_q     <= hit_d;
            dir_q     <= dir_d;
            hit_idx_q <= hit_idx_d;
        end
    end

    assign bus.o_alive   = alive_q;
    assign bus.o_score   = score_q;
    assign bus.o_hit     = hit_q;
    assign bus.o_hit_dir = dir_q;
    assign bus.o_hit_idx = hit_idx_q;
    assign bus.o_busy    = (state_q != ST_IDLE);
    assign bus.o_clear   = (alive_q == '0);
endmodule

// File: doc/brick_field_ctrl.md
Name: brick_field_ctrl

Overview:
- Manages the full wall of breakout bricks as one alive-bitmap instead of one collision instance per brick.
- Once per animation frame it latches the ball centre and scans the bricks sequentially, one per clock.
- On the first live brick that overlaps the ball it retires that brick, bumps the score and reports the bounce direction to the ball logic.
- Sits between the ball/square mover and the renderer/score display.

Parameters:
ROWS, 4, brick rows
COLS, 8, brick columns; N = ROWS*COLS, N <= 64
X0, 60, centre x of column 0
Y0, 40, centre y of row 0
PITCH_X, 74, centre-to-centre horizontal spacing
PITCH_Y, 16, centre-to-centre vertical spacing
B_WIDTH, 30, brick half width
B_HEIGHT, 5, brick half height
S_SIZE, 5, ball half size

Ports:
i_clk  in  1  base clock
i_rst  in  1  synchronous active-high reset
i_ani_stb  in  1  frame strobe, one i_clk cycle wide
i_animate  in  1  scans run only while high
i_load  in  1  reload full wall and zero score
i_col_ack  in  1  ball logic has consumed the bounce; clears o_hit_dir
s_x  in  12  ball centre x
s_y  in  12  ball centre y
o_alive  out  N  bit k = brick k present; row-major, k = row*COLS+col
o_score  out  9  bricks destroyed, saturates at 511
o_hit  out  1  one-cycle pulse on brick retirement
o_hit_dir  out  2  00 none, 01 top/bottom, 10 left/right, 11 corner
o_hit_idx  out  6  index of last retired brick
o_busy  out  1  scan in progress
o_clear  out  1  high while o_alive == 0

Behaviour:
- Reset (i_rst sampled high at edge):
  - o_alive = all ones, o_score = 0, o_hit = 0, o_hit_dir = 00, o_hit_idx = 0
  - o_busy = 0, state IDLE, idx = 0
- States: IDLE, SCAN, DONE.
- IDLE: i_ani_stb && i_animate at edge E latches s_x/s_y into lx/ly, idx := 0, goes to SCAN. o_busy is high from E through the DONE cycle.
- SCAN, brick k = idx:
  - Centre: cx = X0 + col*PITCH_X, cy = Y0 + row*PITCH_Y.
  - Arithmetic: 13-bit signed differences dx = lx - cx, dy = ly - cy.
  - Margins: mx = (B_WIDTH+S_SIZE) - |dx|, my = (B_HEIGHT+S_SIZE) - |dy|.
  - Hit test: alive[k] && mx >= 0 && my >= 0.
  - On hit, at edge E+1+k:
    - alive[k] := 0; score := score+1 (holds at 511)
    - o_hit := 1 for exactly one cycle; o_hit_idx := k
    - o_hit_dir := 11 if mx == my, 01 if my < mx, else 10
    - go to DONE
  - On no hit: if k == N-1 go to DONE, else idx := k+1.
- Only the lowest-index hit per frame is retired.
- Full miss: SCAN lasts N cycles, DONE 1 cycle, then IDLE.
- DONE: return to IDLE next edge.
- i_ani_stb while busy or with i_animate low: ignored, no queueing.
- o_hit_dir holds until i_col_ack is sampled high, then becomes 00. A new hit in the same cycle as i_col_ack wins: the new direction is loaded.
- i_load: highest priority after reset, in any state.
  - alive := all ones, score := 0, o_hit_dir := 00, o_hit := 0
  - state := IDLE; an in-flight scan is aborted
  - o_hit_idx is unchanged
- o_clear is combinational from o_alive. The scanner still runs when clear and finds nothing.
- Ball latch is fixed for the whole scan; s_x/s_y changes mid-scan have no effect.

Test Plan:
- Reset asserted 2 cycles -> o_alive = 32'hFFFFFFFF, o_score = 0, o_hit_dir = 00, o_busy = 0, o_clear = 0.
- Ball (60,50), frame strobe at E:
  - o_hit pulses after E+1 for one cycle; o_hit_idx = 0, o_hit_dir = 01 (my=0, mx=35)
  - o_alive bit0 = 0, o_score = 1, o_busy low after E+2
- Same ball (60,50), next frame:
  - brick 0 dead, so brick 8 (60,56) hits at E+9
  - dir = 01, o_score = 2, alive bit8 = 0
- Ball (100,40):
  - brick 1 (134,40) has mx=1, my=10 -> dir = 10, idx = 1
- Ball (169,50):
  - brick 1 has mx=0, my=0 -> dir = 11; brick 9 also overlaps but is not retired
- Ball (320,300):
  - o_busy high 33 cycles, no o_hit, score unchanged
  - a second strobe at E+5 is ignored
- i_load at E+10 mid-scan -> state IDLE and o_busy = 0 next cycle, o_alive all ones, o_score = 0.
- i_col_ack with o_hit_dir = 10 -> 00 next cycle.
- i_col_ack coincident with a new hit -> o_hit_dir takes the new value.
